// File: rtl/operand_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : operand_accumulator (with full_adder)                      |
// | Description : Streams len N-bit operands through an N-bit full adder and |
// |               returns {carry count, low word} over a valid/ready port.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module full_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign cout = w_carry[N];
endmodule

module operand_accumulator #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N+CNT_W-1:0]   out_sum,
    output logic                 busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [N-1:0]     r_low;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_remaining;
    logic [N-1:0]     w_sum;
    logic             w_cout;
    logic             w_accept;

    full_adder #(.N(N)) u_adder (
        .a    (r_low),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Handshake outputs depend on r_state only, never on the inputs.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (len != '0) ? S_ACC : S_DONE;
                end
            end
            S_ACC: begin
                in_ready = 1'b1;
                if (in_valid && (r_remaining == CNT_W'(1))) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_low       <= '0;
            r_high      <= '0;
            r_remaining <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_low       <= '0;
            r_high      <= '0;
            r_remaining <= len;
        end else if (w_accept) begin
            r_low       <= w_sum;
            r_high      <= r_high + CNT_W'(w_cout);
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

    assign out_sum = {r_high, r_low};
endmodule

`default_nettype wire

// File: tb/tb_operand_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_operand_accumulator                                     |
// | Description : Randomised bench; expected sums come from integer addition.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module tb_operand_accumulator;
    localparam int N     = 8;
    localparam int CNT_W = 4;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [CNT_W-1:0]   len;
    logic               in_valid;
    logic               in_ready;
    logic [N-1:0]       in_data;
    logic               out_valid;
    logic               out_ready;
    logic [N+CNT_W-1:0] out_sum;
    logic               busy;

    int n_compared   = 0;
    int n_mismatched = 0;
    int ops_q[$];

    operand_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Full-precision sum; carries into the high word are just bits above N.
    function automatic logic [31:0] model_sum();
        int total = 0;
        foreach (ops_q[i]) total += ops_q[i];
        return 32'(total) & ((32'd1 << (N + CNT_W)) - 1);
    endfunction

    // Runs ops_q with random gaps in [gap_lo,gap_hi] before each beat, then
    // stalls the output for 'stall' cycles. Spurious starts are injected
    // while busy and on the handshake cycle; all must be ignored.
    task automatic do_run(input int gap_lo, input int gap_hi, input int stall);
        logic [31:0] exp;
        int nlen;
        nlen = ops_q.size();
        exp  = model_sum();
        @(negedge clk);
        start = 1'b1;
        len   = CNT_W'(nlen);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        if (nlen == 0) begin
            chk("zero_len_valid", 32'(out_valid), 32'd1);
            chk("zero_len_ready", 32'(in_ready), 32'd0);
        end else begin
            chk("ready_after_start", 32'(in_ready), 32'd1);
        end
        for (int i = 0; i < nlen; i++) begin
            int gap;
            gap = int'($urandom_range(gap_hi, gap_lo));
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data  = N'($urandom);
                start    = $urandom_range(1, 0) == 1;
                len      = CNT_W'($urandom);
                @(negedge clk);
                start = 1'b0;
                chk("gap_ready", 32'(in_ready), 32'd1);
            end
            in_valid = 1'b1;
            in_data  = N'(ops_q[i]);
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = N'($urandom);
            if (i < nlen - 1) begin
                chk("valid_early", 32'(out_valid), 32'd0);
            end
        end
        chk("valid_after_last", 32'(out_valid), 32'd1);
        chk("ready_in_done", 32'(in_ready), 32'd0);
        chk("sum", 32'(out_sum), exp);
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            start = 1'b1;
            len   = CNT_W'($urandom);
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_sum", 32'(out_sum), exp);
            chk("stall_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 4'd5;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_busy", 32'(busy), 32'd0);
        chk("post_hs_ready", 32'(in_ready), 32'd0);
        chk("post_hs_hold", 32'(out_sum), exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(out_sum), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        ops_q = '{8'h09, 8'h01, 8'h69, 8'h08};
        chk("model_basic", model_sum(), 32'h07B);
        do_run(0, 0, 0);

        ops_q = '{8'hFF, 8'hFF, 8'hFF};
        chk("model_carry", model_sum(), 32'h2FD);
        do_run(0, 0, 1);

        ops_q = {};
        for (int i = 0; i < 15; i++) ops_q.push_back(8'hFF);
        chk("model_max", model_sum(), 32'hEF1);
        do_run(0, 1, 0);

        ops_q = {};
        do_run(0, 0, 2);

        ops_q = '{8'h10, 8'h20, 8'h30};
        chk("model_gaps", model_sum(), 32'h060);
        do_run(2, 2, 5);

        // Asynchronous reset in the middle of a 4-beat run.
        @(negedge clk);
        start = 1'b1;
        len   = 4'd4;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h33;
        @(negedge clk);
        in_data = 8'h44;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_sum", 32'(out_sum), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        ops_q = '{8'h05};
        do_run(0, 0, 0);

        for (int r = 0; r < 25; r++) begin
            int rl;
            rl    = int'($urandom_range(15, 0));
            ops_q = {};
            for (int i = 0; i < rl; i++) ops_q.push_back(int'($urandom_range(255, 0)));
            do_run(0, 2, int'($urandom_range(3, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

`default_nettype wire
